// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with imem, feeds IF/ID with a one-entry skid.
// Optional FETCH_PREDECODE_EN registers rs1/rs2/store-flag alongside the instruction.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic        mem_write_out,
  output logic        valid_out
);
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_reg, drain_addr, skid_pc, skid_instr;
  logic        ack;
  logic        load_out;
  logic [31:0] load_pc, load_instr;

  assign imem_req  = ~rst & (state != S_HOLD);
  // DRAIN keeps the abandoned address on the bus until its response is swallowed
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc_reg;
  assign ack       = imem_ack & imem_req;

  always_comb begin
    load_out   = 1'b0;
    load_pc    = pc_reg;
    load_instr = imem_rdata;
    if (!redirect) begin
      if (state == S_FETCH && ack && !stall) begin
        load_out = 1'b1;
      end else if (state == S_HOLD && !stall) begin
        load_out   = 1'b1;
        load_pc    = skid_pc;
        load_instr = skid_instr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc_reg     <= RESET_PC;
      drain_addr <= 32'h0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
      pc_out     <= 32'h0;
      instr_out  <= 32'h0;
      valid_out  <= 1'b0;
    end else if (redirect) begin
      pc_reg     <= redirect_pc & ~32'h3;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
      pc_out     <= 32'h0;
      instr_out  <= 32'h0;
      valid_out  <= 1'b0;
      if (state != S_HOLD && !ack) begin
        state      <= S_DRAIN;
        drain_addr <= imem_addr;
      end else begin
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (ack) begin
            pc_reg <= pc_reg + 32'd4;
            if (stall) begin
              skid_pc    <= pc_reg;
              skid_instr <= imem_rdata;
              state      <= S_HOLD;
            end
          end else if (!stall) begin
            valid_out <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) state <= S_FETCH;
        end
        S_DRAIN: begin
          valid_out <= 1'b0;
          if (ack) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
      if (load_out) begin
        pc_out    <= load_pc;
        instr_out <= load_instr;
        valid_out <= 1'b1;
      end
    end
  end

`ifdef FETCH_PREDECODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_out       <= 5'd0;
      rs2_out       <= 5'd0;
      mem_write_out <= 1'b0;
    end else if (redirect) begin
      rs1_out       <= 5'd0;
      rs2_out       <= 5'd0;
      mem_write_out <= 1'b0;
    end else if (load_out) begin
      rs1_out       <= load_instr[19:15];
      rs2_out       <= load_instr[24:20];
      mem_write_out <= (load_instr[6:0] == 7'b0100011);
    end
  end
`else
  assign rs1_out       = 5'd0;
  assign rs2_out       = 5'd0;
  assign mem_write_out = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run scored against an
// in-order PC stream model with a variable-latency memory.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_out, instr_out;
  logic [4:0]  rs1_out, rs2_out;
  logic        mem_write_out, valid_out;

  int n_cmp = 0;
  int n_fail = 0;

  logic [1:0] fixed_lat = 2'd0;
  logic [1:0] rnd_lat = 2'd0;
  bit         rand_lat = 1'b0;
  logic [3:0] cnt;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .mem_write_out(mem_write_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h200) ? 32'h00A12023 : a;
  endfunction

  // memory: acks once a request has been held for `latency` extra cycles
  assign imem_ack   = imem_req && (cnt == {2'b00, (rand_lat ? rnd_lat : fixed_lat)});
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 4'd0;
    else if (!imem_req || imem_ack) begin
      cnt <= 4'd0;
      if (imem_ack) rnd_lat <= 2'($urandom_range(0, 3));
    end else cnt <= cnt + 4'd1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    fixed_lat = 2'd0; rand_lat = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_cmp++; if ({valid_out, pc_out, instr_out} !== 65'h0) begin n_fail++; $display("FAIL reset_outs got v=%b pc=%h i=%h want 0", valid_out, pc_out, instr_out); end
    n_cmp++; if ({rs1_out, rs2_out, mem_write_out} !== 11'h0) begin n_fail++; $display("FAIL reset_pd got %h want 0", {rs1_out, rs2_out, mem_write_out}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_release got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    fixed_lat = 2'd0; rand_lat = 1'b0;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b1 || pc_out !== 32'(4 * (k - 1)) || instr_out !== 32'(4 * (k - 1))) begin
        n_fail++; $display("FAIL stream k=%0d got v=%b pc=%h i=%h want 1/%h", k, valid_out, pc_out, instr_out, 4 * (k - 1));
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    fixed_lat = 2'd0; rand_lat = 1'b0;
    do_reset();
    while (imem_addr !== 32'h10 && n < 20) begin @(negedge clk); n++; end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0 || pc_out !== 32'hC || valid_out !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold k=%0d got req=%b pc=%h v=%b want 0/c/1", k, imem_req, pc_out, valid_out);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pc_out !== 32'h10 || instr_out !== 32'h10 || valid_out !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      n_fail++; $display("FAIL stall_release got pc=%h v=%b req=%b addr=%h want 10/1/1/14", pc_out, valid_out, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_drain();
    int n = 0;
    bit seen = 1'b0;
    fixed_lat = 2'd2; rand_lat = 1'b0;
    do_reset();
    while (imem_addr !== 32'h8 && n < 20) begin @(negedge clk); n++; end
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || valid_out !== 1'b0 || pc_out !== 32'h0) begin
      n_fail++; $display("FAIL drain_state got req=%b addr=%h v=%b pc=%h want 1/8/0/0", imem_req, imem_addr, valid_out, pc_out);
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || pc_out !== 32'h100 || instr_out !== 32'h100) begin
      n_fail++; $display("FAIL drain_first got seen=%b pc=%h i=%h want 1/100/100", seen, pc_out, instr_out);
    end
  endtask

  task automatic test_redirect_stall();
    fixed_lat = 2'd0; rand_lat = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0 || pc_out !== 32'h0 || instr_out !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL redir_stall got v=%b pc=%h i=%h req=%b addr=%h want 0/0/0/1/40", valid_out, pc_out, instr_out, imem_req, imem_addr);
    end
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b1 || pc_out !== 32'h40) begin
      n_fail++; $display("FAIL redir_stall_next got v=%b pc=%h want 1/40", valid_out, pc_out);
    end
  endtask

  task automatic test_predecode();
    logic [4:0] e_rs1, e_rs2;
    logic       e_mw;
`ifdef FETCH_PREDECODE_EN
    e_rs1 = 5'd2; e_rs2 = 5'd10; e_mw = 1'b1;
`else
    e_rs1 = 5'd0; e_rs2 = 5'd0; e_mw = 1'b0;
`endif
    fixed_lat = 2'd0; rand_lat = 1'b0;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b1 || pc_out !== 32'h200 || instr_out !== 32'h00A12023) begin
      n_fail++; $display("FAIL store_fetch got v=%b pc=%h i=%h want 1/200/00a12023", valid_out, pc_out, instr_out);
    end
    n_cmp++;
    if (rs1_out !== e_rs1 || rs2_out !== e_rs2 || mem_write_out !== e_mw) begin
      n_fail++; $display("FAIL predecode got rs1=%0d rs2=%0d mw=%b want %0d/%0d/%b", rs1_out, rs2_out, mem_write_out, e_rs1, e_rs2, e_mw);
    end
  endtask

  task automatic test_wrap();
    fixed_lat = 2'd0; rand_lat = 1'b0;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr); end
    @(negedge clk);
    n_cmp++;
    if (pc_out !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr1 got pc=%h addr=%h want fffffffc/0", pc_out, imem_addr);
    end
    @(negedge clk);
    n_cmp++; if (pc_out !== 32'h0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL wrap_pc got pc=%h v=%b want 0/1", pc_out, valid_out); end
  endtask

  // Model: valid presentations follow an in-order PC stream restarting at each redirect
  // target; a stalled cycle freezes every output; a redirect zeroes them.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic        p_stall = 1'b0, p_redir = 1'b0, p_req = 1'b0, p_ack = 1'b0;
    logic [31:0] p_rpc = 32'h0, p_addr = 32'h0, p_pc = 32'h0, p_instr = 32'h0;
    logic        p_valid = 1'b0;
    int          n_valid = 0;
    rand_lat = 1'b1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (p_req && !p_ack) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          n_fail++; $display("FAIL rnd_req_stable c=%0d got req=%b addr=%h want 1/%h", c, imem_req, imem_addr, p_addr);
        end
      end
      if (p_redir) begin
        n_cmp++;
        if (valid_out !== 1'b0 || pc_out !== 32'h0 || instr_out !== 32'h0) begin
          n_fail++; $display("FAIL rnd_redir_zero c=%0d got v=%b pc=%h i=%h want 0", c, valid_out, pc_out, instr_out);
        end
        exp_pc = p_rpc & ~32'h3;
      end else if (p_stall) begin
        n_cmp++;
        if (valid_out !== p_valid || pc_out !== p_pc || instr_out !== p_instr) begin
          n_fail++; $display("FAIL rnd_hold c=%0d got v=%b pc=%h i=%h want %b/%h/%h", c, valid_out, pc_out, instr_out, p_valid, p_pc, p_instr);
        end
      end else if (valid_out) begin
        n_cmp++;
        if (pc_out !== exp_pc || instr_out !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rnd_stream c=%0d got pc=%h i=%h want %h/%h", c, pc_out, instr_out, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        n_valid++;
      end
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = $urandom & 32'h3FF;
      p_stall = stall; p_redir = redirect; p_rpc = redirect_pc;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_valid = valid_out; p_pc = pc_out; p_instr = instr_out;
    end
    stall = 1'b0; redirect = 1'b0;
    n_cmp++; if (n_valid < 100) begin n_fail++; $display("FAIL rnd_progress got %0d want >=100", n_valid); end
    rand_lat = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_stall();
    test_predecode();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
